semaphore_arb: RTL

SEMAPHORE_ARB -- requirements
Module: semaphore_arb

---
 rtl/semaphore_arb_if.sv | 43 ++++
 rtl/semaphore_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/semaphore_arb_if.sv
// semaphore_arb_if -- bus bundle between the requesters, the arbiter and the
// downstream semaphore register block.
//
// Parameters: NREQ requesters, DW data width, AW address width, BW byte-enable width.
// Requester side (flattened per requester i at [i*W +: W]):
//   req_cs, req_wr, req_addr, req_wdata, req_be  -> arbiter
//   req_rdata (shared), req_ack (one-hot pulse)  <- arbiter
// Semaphore side:
//   sem_cs, sem_wr, sem_addr, sem_wdata, sem_be  <- arbiter
//   sem_rdata, sem_ack                           -> arbiter
// Modports: slave = arbiter view, master = environment view.
interface semaphore_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int BW   = 2
) ();
  logic [NREQ-1:0]    req_cs;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*BW-1:0] req_be;
  logic [DW-1:0]      req_rdata;
  logic [NREQ-1:0]    req_ack;

  logic               sem_cs;
  logic               sem_wr;
  logic [AW-1:0]      sem_addr;
  logic [DW-1:0]      sem_wdata;
  logic [BW-1:0]      sem_be;
  logic [DW-1:0]      sem_rdata;
  logic               sem_ack;

  modport slave (
    input  req_cs, req_wr, req_addr, req_wdata, req_be, sem_rdata, sem_ack,
    output req_rdata, req_ack, sem_cs, sem_wr, sem_addr, sem_wdata, sem_be
  );

  modport master (
    output req_cs, req_wr, req_addr, req_wdata, req_be, sem_rdata, sem_ack,
    input  req_rdata, req_ack, sem_cs, sem_wr, sem_addr, sem_wdata, sem_be
  );
endinterface

// File: rtl/semaphore_arb.sv
// semaphore_arb -- round-robin arbiter letting NREQ requesters share one
// semaphore register block, with exactly one downstream access in flight.
//
// Ports:
//   mclk         clock, all state on rising edge
//   h_reset_n    asynchronous active-low reset
//   bus          semaphore_arb_if.slave (requester and semaphore buses)
//   arb_err_clr  clears the sticky timeout flag
//   arb_err      sticky timeout flag
//
// Optional feature: define SEMAPHORE_ARB_TIMEOUT_EN to add a 16-cycle
// downstream timeout that completes the access with zero data and sets
// arb_err. Without it BUSY waits for sem_ack indefinitely and arb_err is 0.
//
// Flow: IDLE grants the next requester at or after rr_ptr and latches its
// request into the sem_* registers; BUSY holds those until sem_ack; RESP
// carries the single-cycle req_ack pulse and blocks a new grant.
module semaphore_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int BW   = 2
) (
  input  logic           mclk,
  input  logic           h_reset_n,
  semaphore_arb_if.slave bus,
  input  logic           arb_err_clr,
  output logic           arb_err
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic            sem_cs_reg, sem_cs_next;
  logic            sem_wr_reg, sem_wr_next;
  logic [AW-1:0]   sem_addr_reg, sem_addr_next;
  logic [DW-1:0]   sem_wdata_reg, sem_wdata_next;
  logic [BW-1:0]   sem_be_reg, sem_be_next;
  logic [DW-1:0]   req_rdata_reg, req_rdata_next;
  logic [NREQ-1:0] req_ack_reg, req_ack_next;
  logic [NREQ-1:0] ack_onehot;

`ifdef SEMAPHORE_ARB_TIMEOUT_EN
  logic [3:0]      tmo_reg, tmo_next;
  logic            arb_err_reg, arb_err_next;
`endif

  // Unpack the flattened request fields so the grant index selects directly.
  logic            wr_arr    [NREQ];
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [BW-1:0]   be_arr    [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign wr_arr[gi]    = bus.req_wr[gi];
      assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = bus.req_wdata[gi*DW +: DW];
      assign be_arr[gi]    = bus.req_be[gi*BW +: BW];
    end
  endgenerate

  // Round-robin search: first asserted req_cs starting at rr_ptr, wrapping.
  logic          found;
  logic [IW-1:0] pick;

  always_comb begin
    logic [IW:0] sum;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_reg} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && bus.req_cs[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  assign ack_onehot = NREQ'(1) << grant_reg;

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    sem_cs_next    = sem_cs_reg;
    sem_wr_next    = sem_wr_reg;
    sem_addr_next  = sem_addr_reg;
    sem_wdata_next = sem_wdata_reg;
    sem_be_next    = sem_be_reg;
    req_rdata_next = req_rdata_reg;
    req_ack_next   = '0;
`ifdef SEMAPHORE_ARB_TIMEOUT_EN
    tmo_next       = '0;
    // A timeout detected below overrides a simultaneous clear.
    arb_err_next   = arb_err_clr ? 1'b0 : arb_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next     = pick;
          rr_ptr_next    = (pick == IW'(NREQ-1)) ? '0 : pick + 1'b1;
          sem_cs_next    = 1'b1;
          sem_wr_next    = wr_arr[pick];
          sem_addr_next  = addr_arr[pick];
          sem_wdata_next = wdata_arr[pick];
          sem_be_next    = be_arr[pick];
          state_next     = BUSY;
        end
      end
      BUSY: begin
        if (bus.sem_ack) begin
          // Drop sem_cs right away so the target sees only one access.
          sem_cs_next    = 1'b0;
          req_rdata_next = bus.sem_rdata;
          req_ack_next   = ack_onehot;
          state_next     = RESP;
        end
`ifdef SEMAPHORE_ARB_TIMEOUT_EN
        else if (tmo_reg == 4'hF) begin
          sem_cs_next    = 1'b0;
          req_rdata_next = '0;
          req_ack_next   = ack_onehot;
          arb_err_next   = 1'b1;
          state_next     = RESP;
        end else begin
          tmo_next = tmo_reg + 4'd1;
        end
`endif
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      sem_cs_reg    <= 1'b0;
      sem_wr_reg    <= 1'b0;
      sem_addr_reg  <= '0;
      sem_wdata_reg <= '0;
      sem_be_reg    <= '0;
      req_rdata_reg <= '0;
      req_ack_reg   <= '0;
`ifdef SEMAPHORE_ARB_TIMEOUT_EN
      tmo_reg       <= '0;
      arb_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      sem_cs_reg    <= sem_cs_next;
      sem_wr_reg    <= sem_wr_next;
      sem_addr_reg  <= sem_addr_next;
      sem_wdata_reg <= sem_wdata_next;
      sem_be_reg    <= sem_be_next;
      req_rdata_reg <= req_rdata_next;
      req_ack_reg   <= req_ack_next;
`ifdef SEMAPHORE_ARB_TIMEOUT_EN
      tmo_reg       <= tmo_next;
      arb_err_reg   <= arb_err_next;
`endif
    end
  end

  assign bus.sem_cs    = sem_cs_reg;
  assign bus.sem_wr    = sem_wr_reg;
  assign bus.sem_addr  = sem_addr_reg;
  assign bus.sem_wdata = sem_wdata_reg;
  assign bus.sem_be    = sem_be_reg;
  assign bus.req_rdata = req_rdata_reg;
  assign bus.req_ack   = req_ack_reg;

`ifdef SEMAPHORE_ARB_TIMEOUT_EN
  assign arb_err = arb_err_reg;
`else
  assign arb_err = 1'b0;
  wire unused_arb_err_clr = arb_err_clr;
`endif

endmodule
